mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DPRIO, default 1: 1 = data requester wins ties; 0 = round-robin between instruction and data.
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
REQ-004 imemory_valid/instr  in  1/1  instruction-side request pulse and instr flag.
REQ-005 imemory_addr/wdata/wstrb  in  32/32/4  instruction-side request fields.
REQ-006 imemory_rdata/ready  out  32/1  instruction-side response data and one-cycle ready pulse.
REQ-007 dmemory_valid/instr/addr/wdata/wstrb  in  1/1/32/32/4  data-side request, same meaning as REQ-004/005.
REQ-008 dmemory_rdata/ready  out  32/1  data-side response.
REQ-009 mem_valid/instr/addr/wdata/wstrb  out  1/1/32/32/4  shared slave request, valid is a one-cycle pulse.
REQ-010 mem_rdata/ready  in  32/1  shared slave response; ready is a one-cycle pulse.

Function
REQ-011 Requester protocol: a requester SHALL NOT pulse valid again before its ready; a second valid while its request is pending or in flight SHALL be ignored.
REQ-012 Each side SHALL have a one-entry pending buffer that holds instr/addr/wdata/wstrb when valid arrives but is not issued that cycle.
REQ-013 FSM states: IDLE, BUSY_I, BUSY_D; reset state IDLE.
REQ-014 Candidate for a side = live valid this cycle or pending entry set; a live request SHALL be issued from live inputs, a pending one from the buffer.
REQ-015 IDLE with a candidate: mem_valid SHALL assert in the same cycle (zero added latency); next state is BUSY of the granted side.
REQ-016 Tie (both candidates): DPRIO=1 grants data; DPRIO=0 grants the side not granted last; last-grant register resets to data, so instruction wins the first tie.
REQ-017 BUSY_x: mem_valid=0 unless REQ-019 applies; new valids from either side are captured in pending buffers.
REQ-018 BUSY_x with mem_ready=1: owner x gets ready=1 and rdata=mem_rdata in the same cycle; the other side gets ready=0, rdata=0.
REQ-019 Same cycle as REQ-018, if any candidate exists (including a live valid arriving that cycle), the next request SHALL be issued back-to-back under REQ-016 and the FSM moves to that BUSY state; otherwise to IDLE.
REQ-020 A side that completes in a cycle SHALL NOT be re-granted in that cycle, even if it also drives valid (REQ-011 violation, ignored).
REQ-021 Issuing a request clears that side's pending entry in the same edge.
REQ-022 mem_ready in IDLE SHALL be ignored; both ready outputs stay 0.
REQ-023 Fields not in use: mem_* outputs SHALL be 0 when mem_valid=0; response outputs 0 when ready=0.
REQ-024 Maximum one outstanding slave transaction at any time.

Reset
REQ-025 On reset==0: FSM IDLE, both pending entries cleared, last-grant = data, all outputs 0 regardless of inputs.
REQ-026 Reset mid-transaction: in-flight request is abandoned; a later mem_ready is dropped per REQ-022; no ready pulse to either side.
REQ-027 Pending buffers hold no value across reset; first request after reset release is arbitrated fresh.

Verification
REQ-028 Idle single request: dmemory_valid, addr=0x80000010 at cycle 0 -> mem_valid=1, mem_addr=0x80000010 cycle 0; mem_ready+rdata=0xDEADBEEF cycle 3 -> dmemory_ready=1, rdata=0xDEADBEEF cycle 3, imemory_ready=0.
REQ-029 Simultaneous valids, DPRIO=1: i addr 0x100, d addr 0x200 cycle 0 -> mem_addr=0x200 cycle 0; mem_ready cycle 2 -> dmemory_ready cycle 2 and mem_valid, mem_addr=0x100 cycle 2; mem_ready cycle 4 -> imemory_ready cycle 4.
REQ-030 DPRIO=0 round-robin: two consecutive simultaneous-valid rounds -> grant order I, D, then D, I.
REQ-031 Arrival during busy: d granted cycle 0, imemory_valid wstrb=0xF wdata=0x12345678 cycle 1 -> mem_valid with buffered wstrb=0xF, wdata=0x12345678 in mem_ready cycle of d.
REQ-032 Reset mid-operation: request issued cycle 0, reset low cycle 1-2, stray mem_ready cycle 3 -> both ready outputs 0, mem_valid 0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction and data ports share one slave.
// Each side owns a one-entry pending buffer; a request is issued in the
// cycle it becomes eligible, and at most one slave transaction is in flight.
module mem_arbiter #(
    parameter bit DPRIO = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        imemory_valid,
    input  logic        imemory_instr,
    input  logic [31:0] imemory_addr,
    input  logic [31:0] imemory_wdata,
    input  logic [3:0]  imemory_wstrb,
    output logic [31:0] imemory_rdata,
    output logic        imemory_ready,

    input  logic        dmemory_valid,
    input  logic        dmemory_instr,
    input  logic [31:0] dmemory_addr,
    input  logic [31:0] dmemory_wdata,
    input  logic [3:0]  dmemory_wstrb,
    output logic [31:0] dmemory_rdata,
    output logic        dmemory_ready,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_e state_q, state_d;
    logic   i_pend_q, i_pend_d;
    logic   d_pend_q, d_pend_d;
    req_t   i_buf_q, i_buf_d;
    req_t   d_buf_q, d_buf_d;
    // Winner of the most recent tie: 1 = data. Only ties move it.
    logic   last_d_q, last_d_d;

    req_t   i_live, d_live;
    req_t   issue_req;
    logic   done;
    logic   can_issue;
    logic   i_accept, d_accept;
    logic   i_cand, d_cand;
    logic   grant_i, grant_d;

    // Arbitration, pending-buffer update and next-state selection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        i_live    = '{imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
        d_live    = '{dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};
        done      = (state_q != IDLE) && mem_ready;
        can_issue = (state_q == IDLE) || done;

        // A live valid counts only if that side has nothing pending or in flight;
        // this also drops a valid from the side completing this cycle.
        i_accept  = imemory_valid && !i_pend_q && (state_q != BUSY_I);
        d_accept  = dmemory_valid && !d_pend_q && (state_q != BUSY_D);
        i_cand    = i_accept || i_pend_q;
        d_cand    = d_accept || d_pend_q;

        grant_i   = 1'b0;
        grant_d   = 1'b0;
        last_d_d  = last_d_q;
        if (can_issue) begin
            if (i_cand && d_cand) begin
                if (DPRIO) begin
                    grant_d = 1'b1;
                end else begin
                    grant_d = !last_d_q;
                    grant_i = last_d_q;
                end
                last_d_d = grant_d;
            end else begin
                grant_i = i_cand;
                grant_d = d_cand;
            end
        end

        issue_req = '0;
        if (grant_i) begin
            issue_req = i_pend_q ? i_buf_q : i_live;
        end else if (grant_d) begin
            issue_req = d_pend_q ? d_buf_q : d_live;
        end

        state_d = state_q;
        if (grant_i) begin
            state_d = BUSY_I;
        end else if (grant_d) begin
            state_d = BUSY_D;
        end else if (done) begin
            state_d = IDLE;
        end

        i_pend_d = i_pend_q;
        i_buf_d  = i_buf_q;
        if (grant_i) begin
            i_pend_d = 1'b0;
        end else if (i_accept) begin
            i_pend_d = 1'b1;
            i_buf_d  = i_live;
        end

        d_pend_d = d_pend_q;
        d_buf_d  = d_buf_q;
        if (grant_d) begin
            d_pend_d = 1'b0;
        end else if (d_accept) begin
            d_pend_d = 1'b1;
            d_buf_d  = d_live;
        end
    end

    // Outputs: slave request and the owner's response, all forced to 0 in reset.
    always_comb begin
        mem_valid     = 1'b0;
        mem_instr     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        imemory_ready = 1'b0;
        imemory_rdata = '0;
        dmemory_ready = 1'b0;
        dmemory_rdata = '0;
        if (reset) begin
            mem_valid = grant_i || grant_d;
            {mem_instr, mem_addr, mem_wdata, mem_wstrb} = issue_req;
            if (done && (state_q == BUSY_I)) begin
                imemory_ready = 1'b1;
                imemory_rdata = mem_rdata;
            end
            if (done && (state_q == BUSY_D)) begin
                dmemory_ready = 1'b1;
                dmemory_rdata = mem_rdata;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            i_pend_q <= 1'b0;
            d_pend_q <= 1'b0;
            // NOTE: buffer payloads are cleared too so nothing from before reset can ever be issued.
            i_buf_q  <= '0;
            d_buf_q  <= '0;
            last_d_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            i_pend_q <= i_pend_d;
            d_pend_q <= d_pend_d;
            i_buf_q  <= i_buf_d;
            d_buf_q  <= d_buf_d;
            last_d_q <= last_d_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (DPRIO=1 and DPRIO=0) share the same
// stimulus; a per-instance transaction-level model predicts every output each
// cycle, and directed scenarios add hand-computed expectations.
module tb_mem_arbiter;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clock;
    logic        reset;
    logic        iv, ii, dv, di, mready;
    logic [31:0] ia, iw, da, dw, mrdata;
    logic [3:0]  is, ds;

    logic [31:0] o_irdata [2];
    logic        o_iready [2];
    logic [31:0] o_drdata [2];
    logic        o_dready [2];
    logic        o_mv     [2];
    logic        o_mi     [2];
    logic [31:0] o_ma     [2];
    logic [31:0] o_mw     [2];
    logic [3:0]  o_ms     [2];

    int cmp_count = 0;
    int err_count = 0;

    // Model state per instance: pending entries, current owner (-1 none,
    // 0 instr, 1 data) and the winner of the most recent tie.
    bit   m_pend  [2][2];
    req_t m_buf   [2][2];
    int   m_owner [2];
    int   m_tie   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.DPRIO(g == 0 ? 1'b1 : 1'b0)) u_dut (
            .clock         (clock),
            .reset         (reset),
            .imemory_valid (iv),
            .imemory_instr (ii),
            .imemory_addr  (ia),
            .imemory_wdata (iw),
            .imemory_wstrb (is),
            .imemory_rdata (o_irdata[g]),
            .imemory_ready (o_iready[g]),
            .dmemory_valid (dv),
            .dmemory_instr (di),
            .dmemory_addr  (da),
            .dmemory_wdata (dw),
            .dmemory_wstrb (ds),
            .dmemory_rdata (o_drdata[g]),
            .dmemory_ready (o_dready[g]),
            .mem_valid     (o_mv[g]),
            .mem_instr     (o_mi[g]),
            .mem_addr      (o_ma[g]),
            .mem_wdata     (o_mw[g]),
            .mem_wstrb     (o_ms[g]),
            .mem_rdata     (mrdata),
            .mem_ready     (mready)
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input int k);
        for (int s = 0; s < 2; s++) begin
            m_pend[k][s] = 1'b0;
            m_buf[k][s]  = '0;
        end
        m_owner[k] = -1;
        m_tie[k]   = 1;
    endtask

    // Advance to just after the next rising edge and idle all pulse inputs.
    task automatic next_cycle();
        @(posedge clock);
        #1;
        iv = 0; ii = 0; ia = 0; iw = 0; is = 0;
        dv = 0; di = 0; da = 0; dw = 0; ds = 0;
        mready = 0; mrdata = 0;
    endtask

    // Predict this cycle's outputs, compare both instances, commit model state.
    task automatic evaluate();
        #1;
        for (int k = 0; k < 2; k++) begin
            req_t        live [2];
            bit          vin  [2];
            bit          acc  [2];
            bit          cand [2];
            logic        e_rdy [2];
            logic [31:0] e_rd  [2];
            req_t        e_req;
            logic        e_mv;
            bit          done;
            int          pick;
            live[0] = '{ii, ia, iw, is};
            live[1] = '{di, da, dw, ds};
            vin[0]  = iv;
            vin[1]  = dv;
            e_rdy[0] = 0; e_rdy[1] = 0;
            e_rd[0]  = 0; e_rd[1]  = 0;
            e_req = '0;
            e_mv  = 0;
            if (!reset) begin
                model_clear(k);
            end else begin
                done = (m_owner[k] >= 0) && mready;
                if (done) begin
                    e_rdy[m_owner[k]] = 1;
                    e_rd[m_owner[k]]  = mrdata;
                end
                for (int s = 0; s < 2; s++) begin
                    acc[s]  = vin[s] && !m_pend[k][s] && (m_owner[k] != s);
                    cand[s] = acc[s] || m_pend[k][s];
                end
                pick = -1;
                if (m_owner[k] < 0 || done) begin
                    if (cand[0] && cand[1]) begin
                        pick = (k == 0) ? 1 : 1 - m_tie[k];
                        m_tie[k] = pick;
                    end else if (cand[1]) begin
                        pick = 1;
                    end else if (cand[0]) begin
                        pick = 0;
                    end
                end
                if (pick >= 0) begin
                    e_mv  = 1;
                    e_req = m_pend[k][pick] ? m_buf[k][pick] : live[pick];
                end
                for (int s = 0; s < 2; s++) begin
                    if (s == pick) begin
                        m_pend[k][s] = 0;
                    end else if (acc[s]) begin
                        m_pend[k][s] = 1;
                        m_buf[k][s]  = live[s];
                    end
                end
                if (pick >= 0) m_owner[k] = pick;
                else if (done) m_owner[k] = -1;
            end
            check($sformatf("u%0d.mem_valid", k), 32'(o_mv[k]), 32'(e_mv));
            check($sformatf("u%0d.mem_instr", k), 32'(o_mi[k]), 32'(e_req.instr));
            check($sformatf("u%0d.mem_addr", k), o_ma[k], e_req.addr);
            check($sformatf("u%0d.mem_wdata", k), o_mw[k], e_req.wdata);
            check($sformatf("u%0d.mem_wstrb", k), 32'(o_ms[k]), 32'(e_req.wstrb));
            check($sformatf("u%0d.imemory_ready", k), 32'(o_iready[k]), 32'(e_rdy[0]));
            check($sformatf("u%0d.imemory_rdata", k), o_irdata[k], e_rd[0]);
            check($sformatf("u%0d.dmemory_ready", k), 32'(o_dready[k]), 32'(e_rdy[1]));
            check($sformatf("u%0d.dmemory_rdata", k), o_drdata[k], e_rd[1]);
        end
    endtask

    // One reset cycle with busy inputs (outputs must stay 0), then one idle cycle.
    task automatic do_reset();
        next_cycle();
        reset = 0; dv = 1; da = 32'h1234; iv = 1; mready = 1; mrdata = 32'hFFFF;
        evaluate();
        check("rst.mem_valid", 32'(o_mv[0]), 0);
        check("rst.mem_addr", o_ma[0], 0);
        check("rst.dmemory_ready", 32'(o_dready[1]), 0);
        next_cycle();
        reset = 1;
        evaluate();
    endtask

    initial begin
        reset = 0;
        iv = 0; ii = 0; ia = 0; iw = 0; is = 0;
        dv = 0; di = 0; da = 0; dw = 0; ds = 0;
        mready = 0; mrdata = 0;
        for (int k = 0; k < 2; k++) model_clear(k);

        // Idle single data request, response three cycles later.
        do_reset();
        next_cycle(); dv = 1; da = 32'h8000_0010; evaluate();
        check("single.mem_valid", 32'(o_mv[0]), 1);
        check("single.mem_addr", o_ma[0], 32'h8000_0010);
        next_cycle(); evaluate();
        next_cycle(); evaluate();
        next_cycle(); mready = 1; mrdata = 32'hDEAD_BEEF; evaluate();
        check("single.dmemory_ready", 32'(o_dready[0]), 1);
        check("single.dmemory_rdata", o_drdata[0], 32'hDEAD_BEEF);
        check("single.imemory_ready", 32'(o_iready[0]), 0);

        // Simultaneous valids: data priority on u0, instruction first tie on u1.
        do_reset();
        next_cycle(); iv = 1; ia = 32'h100; dv = 1; da = 32'h200; evaluate();
        check("tie.u0.mem_addr", o_ma[0], 32'h200);
        check("tie.u1.mem_addr", o_ma[1], 32'h100);
        next_cycle(); evaluate();
        next_cycle(); mready = 1; mrdata = 32'hA5; evaluate();
        check("tie.u0.dmemory_ready", 32'(o_dready[0]), 1);
        check("tie.u0.b2b_valid", 32'(o_mv[0]), 1);
        check("tie.u0.b2b_addr", o_ma[0], 32'h100);
        next_cycle(); evaluate();
        next_cycle(); mready = 1; mrdata = 32'h5A; evaluate();
        check("tie.u0.imemory_ready", 32'(o_iready[0]), 1);
        check("tie.u0.imemory_rdata", o_irdata[0], 32'h5A);
        check("tie.u0.idle_valid", 32'(o_mv[0]), 0);

        // Round robin on u1: grant order I, D then D, I.
        do_reset();
        next_cycle(); iv = 1; ia = 32'h100; dv = 1; da = 32'h200; evaluate();
        check("rr.r1.first", o_ma[1], 32'h100);
        next_cycle(); mready = 1; evaluate();
        check("rr.r1.second", o_ma[1], 32'h200);
        next_cycle(); mready = 1; evaluate();
        next_cycle(); iv = 1; ia = 32'h300; dv = 1; da = 32'h400; evaluate();
        check("rr.r2.first", o_ma[1], 32'h400);
        next_cycle(); mready = 1; evaluate();
        check("rr.r2.second", o_ma[1], 32'h300);
        next_cycle(); mready = 1; evaluate();

        // Instruction arrival while data is busy is buffered and issued back-to-back.
        do_reset();
        next_cycle(); dv = 1; da = 32'h40; evaluate();
        next_cycle(); iv = 1; ia = 32'h44; iw = 32'h1234_5678; is = 4'hF; evaluate();
        next_cycle(); evaluate();
        next_cycle(); mready = 1; evaluate();
        check("buf.mem_valid", 32'(o_mv[0]), 1);
        check("buf.mem_addr", o_ma[0], 32'h44);
        check("buf.mem_wdata", o_mw[0], 32'h1234_5678);
        check("buf.mem_wstrb", 32'(o_ms[0]), 32'hF);
        next_cycle(); mready = 1; evaluate();

        // Reset mid-transaction, then a stray mem_ready and a fresh request.
        do_reset();
        next_cycle(); dv = 1; da = 32'h60; evaluate();
        next_cycle(); reset = 0; dv = 1; evaluate();
        check("midrst.mem_valid", 32'(o_mv[0]), 0);
        next_cycle(); evaluate();
        next_cycle(); reset = 1; mready = 1; mrdata = 32'h77; evaluate();
        check("midrst.dmemory_ready", 32'(o_dready[0]), 0);
        check("midrst.imemory_ready", 32'(o_iready[0]), 0);
        check("midrst.stray_valid", 32'(o_mv[0]), 0);
        next_cycle(); iv = 1; ii = 1; ia = 32'h500; evaluate();
        check("midrst.fresh_valid", 32'(o_mv[0]), 1);
        check("midrst.fresh_addr", o_ma[0], 32'h500);
        check("midrst.fresh_instr", 32'(o_mi[0]), 1);
        next_cycle(); mready = 1; evaluate();

        // Randomized traffic, including stray readies, repeated valids and resets.
        for (int n = 0; n < 4000; n++) begin
            next_cycle();
            if (!reset) reset = ($urandom_range(0, 1) == 0);
            else if ($urandom_range(0, 199) == 0) reset = 0;
            iv = ($urandom_range(0, 99) < 30);
            ii = 1'($urandom);
            ia = $urandom; iw = $urandom; is = 4'($urandom);
            dv = ($urandom_range(0, 99) < 30);
            di = 1'($urandom);
            da = $urandom; dw = $urandom; ds = 4'($urandom);
            mready = ($urandom_range(0, 99) < 35);
            mrdata = $urandom;
            evaluate();
        end

        $display("Result: errors=%0d of %0d checks", err_count, cmp_count);
        $finish;
    end

endmodule
